// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage of the RV32I core.
//
// Registers the memory-stage results and aligns and sign-extends load data.
// Selects the writeback value and drives the register file write port. The
// same write is exported as a forwarding source. A retired-instruction
// counter is also kept here.
//
// Handshake / pipeline control: there is no valid/ready pair here. stall
// holds every register field. flush turns the register into a bubble and
// takes priority over stall. A real instruction enters when neither is
// asserted.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   mem_valid .. mem_pc_plus4     MEM-stage results to capture
//   stall, flush                  pipeline hold / bubble insertion
//   wb_rd, wb_wd, wb_we           register file write port
//   wb_valid                      WB register holds a real instruction
//   fwd_rd, fwd_data, fwd_en      forwarding source, identical to wb_*
//   instret                       retired-instruction counter (wraps)
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_result_src,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_read_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_wd,
  output logic             wb_we,
  output logic             wb_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             fwd_en,
  output logic [CNT_W-1:0] instret
);

  // WB pipeline register fields
  logic            r_valid;
  logic            r_reg_write;
  logic [4:0]      r_rd;
  logic [1:0]      r_src;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_pc;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_src       <= '0;
      r_funct3    <= '0;
      r_alu       <= '0;
      r_rdata     <= '0;
      r_pc        <= '0;
    end else if (flush) begin
      // Only the qualifiers need clearing; the payload is don't-care.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      r_valid     <= mem_valid;
      r_reg_write <= mem_reg_write;
      r_rd        <= mem_rd;
      r_src       <= mem_result_src;
      r_funct3    <= mem_funct3;
      r_alu       <= mem_alu_result;
      r_rdata     <= mem_read_data;
      r_pc        <= mem_pc_plus4;
    end
  end

  // An instruction is counted on the single edge where it enters WB, so a
  // stalled instruction is never counted twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!flush && !stall && mem_valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Load alignment
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] wd;

  always_comb begin
    ld_byte = r_rdata[7:0];
    case (r_alu[1:0])
      2'd0: ld_byte = r_rdata[7:0];
      2'd1: ld_byte = r_rdata[15:8];
      2'd2: ld_byte = r_rdata[23:16];
      2'd3: ld_byte = r_rdata[31:24];
      default: ld_byte = r_rdata[7:0];
    endcase
    // Halfword select ignores off[0]; misaligned halves are not trapped here.
    ld_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];

    ld_data = r_rdata;
    case (r_funct3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = r_rdata;
    endcase

    wd = r_alu;
    case (r_src)
      2'b01:   wd = ld_data;
      2'b10:   wd = r_pc;
      default: wd = r_alu;
    endcase
  end

  assign wb_rd    = r_rd;
  assign wb_wd    = wd;
  assign wb_we    = r_valid & r_reg_write & (r_rd != 5'd0);
  assign wb_valid = r_valid;
  assign fwd_rd   = r_rd;
  assign fwd_data = wd;
  assign fwd_en   = wb_we;
  assign instret  = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage, built with a 4-bit retired-instruction counter so
// that wrap-around can be reached with a short instruction stream.
module tb_wb_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  // expected entry: {valid, we, rd, wd, instret}
  localparam int W     = 1 + 1 + 5 + XLEN + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             mem_valid = 1'b0;
  logic             mem_reg_write = 1'b0;
  logic [4:0]       mem_rd = '0;
  logic [1:0]       mem_result_src = '0;
  logic [2:0]       mem_funct3 = '0;
  logic [XLEN-1:0]  mem_alu_result = '0;
  logic [XLEN-1:0]  mem_read_data = '0;
  logic [XLEN-1:0]  mem_pc_plus4 = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_wd;
  logic             wb_we;
  logic             wb_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             fwd_en;
  logic [CNT_W-1:0] instret;

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result_src(mem_result_src), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
    .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_we(wb_we), .wb_valid(wb_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_en(fwd_en), .instret(instret)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model of the WB register
  logic             m_valid, m_rw;
  logic [4:0]       m_rd;
  logic [1:0]       m_src;
  logic [2:0]       m_f3;
  logic [XLEN-1:0]  m_alu, m_rdata, m_pc;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_rd = 0; m_src = 0; m_f3 = 0;
    m_alu = 0; m_rdata = 0; m_pc = 0; m_cnt = 0;
  endtask

  function automatic logic [XLEN-1:0] model_wd(input logic [1:0] src,
      input logic [2:0] f3, input logic [XLEN-1:0] alu, rdata, pc);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] ld;
    logic [1:0]      off;
    off = alu[1:0];
    b = 8'(rdata >> (8 * off));
    h = 16'(rdata >> (16 * off[1]));
    case (f3)
      3'b000:  ld = {{24{b[7]}}, b};
      3'b100:  ld = {24'h0, b};
      3'b001:  ld = {{16{h[15]}}, h};
      3'b101:  ld = {16'h0, h};
      default: ld = rdata;
    endcase
    if (src == 2'b01)      return ld;
    else if (src == 2'b10) return pc;
    else                   return alu;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wb_we"},    64'(wb_we),    64'h0);
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'h0);
    check({tag, ".wb_rd"},    64'(wb_rd),    64'h0);
    check({tag, ".wb_wd"},    64'(wb_wd),    64'h0);
    check({tag, ".fwd_en"},   64'(fwd_en),   64'h0);
    check({tag, ".fwd_rd"},   64'(fwd_rd),   64'h0);
    check({tag, ".fwd_data"}, 64'(fwd_data), 64'h0);
    check({tag, ".instret"},  64'(instret),  64'h0);
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic check_out(input string tag);
    logic [W-1:0]     e;
    logic             e_valid, e_we;
    logic [4:0]       e_rd;
    logic [XLEN-1:0]  e_wd;
    logic [CNT_W-1:0] e_cnt;
    e = exp_q.pop_front();
    {e_valid, e_we, e_rd, e_wd, e_cnt} = e;
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'(e_valid));
    check({tag, ".wb_we"},    64'(wb_we),    64'(e_we));
    check({tag, ".fwd_en"},   64'(fwd_en),   64'(e_we));
    check({tag, ".instret"},  64'(instret),  64'(e_cnt));
    // payload fields are don't-care for a bubble
    if (e_valid) begin
      check({tag, ".wb_rd"},    64'(wb_rd),    64'(e_rd));
      check({tag, ".wb_wd"},    64'(wb_wd),    64'(e_wd));
      check({tag, ".fwd_rd"},   64'(fwd_rd),   64'(e_rd));
      check({tag, ".fwd_data"}, 64'(fwd_data), 64'(e_wd));
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; applies inputs, advances the model,
  // pushes the expectation, then checks one edge later.
  task automatic drive(input string tag, input logic v, rw, input logic [4:0] rd,
      input logic [1:0] src, input logic [2:0] f3,
      input logic [XLEN-1:0] alu, rdata, pc, input logic st, fl);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_result_src = src;
    mem_funct3 = f3; mem_alu_result = alu; mem_read_data = rdata;
    mem_pc_plus4 = pc; stall = st; flush = fl;
    if (fl) begin
      m_valid = 0; m_rw = 0;
    end else if (!st) begin
      m_valid = v; m_rw = rw; m_rd = rd; m_src = src; m_f3 = f3;
      m_alu = alu; m_rdata = rdata; m_pc = pc;
      if (v) m_cnt = m_cnt + 1'b1;
    end
    exp_q.push_back({m_valid, m_valid & m_rw & (m_rd != 5'd0), m_rd,
                     model_wd(m_src, m_f3, m_alu, m_rdata, m_pc), m_cnt});
    @(posedge clk); #1;
    check_out(tag);
  endtask

  task automatic drive_alu(input string tag, input logic [4:0] rd, input logic [XLEN-1:0] alu);
    drive(tag, 1, 1, rd, 2'b00, 3'b010, alu, $urandom, $urandom, 0, 0);
  endtask

  task automatic drive_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
      input logic [XLEN-1:0] exp_wd);
    drive(tag, 1, 1, 5'd9, 2'b01, f3, {28'h0001000, 2'b00, off}, 32'h80FF7F01, 32'h0, 0, 0);
    check({tag, ".literal"}, 64'(wb_wd), 64'(exp_wd));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();

    // Reset held with random inputs: all outputs stay 0.
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'($urandom_range(1, 31));
      mem_result_src = 2'($urandom); mem_funct3 = 3'($urandom);
      mem_alu_result = $urandom; mem_read_data = $urandom; mem_pc_plus4 = $urandom;
      stall = 1'($urandom); flush = 1'($urandom);
      @(posedge clk); #1;
      check_zero("reset");
    end
    rst = 1'b0;

    // First ALU op after reset
    drive_alu("alu_first", 5'd5, 32'h25);
    check("alu_first.rd_lit",  64'(wb_rd),   64'd5);
    check("alu_first.wd_lit",  64'(wb_wd),   64'h25);
    check("alu_first.cnt_lit", 64'(instret), 64'd1);

    // Load alignment on 32'h80FF7F01
    drive_load("lb_off2",  3'b000, 2'd2, 32'hFFFFFFFF);
    drive_load("lbu_off3", 3'b100, 2'd3, 32'h00000080);
    drive_load("lh_off2",  3'b001, 2'd2, 32'hFFFF80FF);
    drive_load("lhu_off0", 3'b101, 2'd0, 32'h00007F01);
    drive_load("lw_off1",  3'b010, 2'd1, 32'h80FF7F01);
    drive_load("lb_off1",  3'b000, 2'd1, 32'h0000007F);
    drive_load("lh_off3",  3'b001, 2'd3, 32'hFFFF80FF);

    // PC+4 source, result_src=11 behaves as ALU, write to x0 suppressed
    drive("pc4", 1, 1, 5'd1, 2'b10, 3'b000, 32'h1234, 32'hDEAD, 32'h40, 0, 0);
    check("pc4.wd_lit", 64'(wb_wd), 64'h40);
    drive("src11", 1, 1, 5'd2, 2'b11, 3'b000, 32'hCAFE, 32'hDEAD, 32'h44, 0, 0);
    drive("x0", 1, 1, 5'd0, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 0, 0);
    check("x0.we_lit",    64'(wb_we),    64'd0);
    check("x0.valid_lit", 64'(wb_valid), 64'd1);
    drive("no_rw", 1, 0, 5'd4, 2'b00, 3'b000, 32'h88, 32'h0, 32'h0, 0, 0);
    drive("bubble", 0, 1, 5'd6, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0, 0, 0);

    // Stall: A is loaded, then held for 3 cycles while inputs change.
    drive("stall_a", 1, 1, 5'd7, 2'b00, 3'b000, 32'h123, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive("stall_hold", 1, 1, 5'($urandom_range(1, 31)), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, 1, 0);
    check("stall.wd_lit", 64'(wb_wd), 64'h123);
    // Flush with stall and mem_valid: bubble, counter unchanged.
    drive("flush_stall", 1, 1, 5'd8, 2'b00, 3'b000, 32'h456, 32'h0, 32'h0, 1, 1);
    check("flush_stall.we_lit",    64'(wb_we),    64'd0);
    check("flush_stall.valid_lit", 64'(wb_valid), 64'd0);
    drive("post_flush", 1, 1, 5'd10, 2'b00, 3'b000, 32'hABC, 32'h0, 32'h0, 0, 0);

    // Async reset between edges while wb_we=1
    drive_alu("pre_rst", 5'd3, 32'h5555);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Counter wrap: 15 ops reach 15, the 16th wraps to 0.
    for (int i = 0; i < 15; i++)
      drive_alu("wrap_fill", 5'($urandom_range(1, 31)), $urandom);
    check("wrap.cnt15", 64'(instret), 64'd15);
    drive_alu("wrap_last", 5'd11, 32'h1);
    check("wrap.cnt0", 64'(instret), 64'd0);

    check("scoreboard.empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Final pipeline stage of the RV32I core. Registers memory-stage results, aligns and sign-extends load data, selects the writeback value and drives the register file write port (address, data, write enable). It also exports the same write as a forwarding source and keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath width. Only 32 is supported.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_valid  input  1  MEM stage holds a real instruction
mem_reg_write  input  1  instruction writes rd
mem_rd  input  5  destination register index
mem_result_src  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 ALU
mem_funct3  input  3  load size and sign code
mem_alu_result  input  XLEN  ALU result or load address
mem_read_data  input  XLEN  raw word from data memory
mem_pc_plus4  input  XLEN  PC+4 of the instruction
stall  input  1  hold the WB register contents
flush  input  1  insert a bubble
wb_rd  output  5  register file write address
wb_wd  output  XLEN  register file write data
wb_we  output  1  register file write enable
wb_valid  output  1  WB register holds a real instruction
fwd_rd  output  5  forwarding destination; equals wb_rd
fwd_data  output  XLEN  forwarding data; equals wb_wd
fwd_en  output  1  forwarding valid; equals wb_we
instret  output  CNT_W  retired-instruction count

Behaviour:
- Pipeline register fields: valid, reg_write, rd, result_src, funct3, alu_result, read_data, pc_plus4.
- rst asserted (asynchronous):
  - All register fields and instret clear to 0.
  - Every output is 0.
  - Effect is immediate, including mid-stall.
- Each posedge, in priority order:
  - flush=1: valid<=0, reg_write<=0. Other fields may keep any value. Flush wins over stall.
  - else stall=1: all fields hold.
  - else: all fields load from the mem_* inputs.
- Latency: one cycle from mem_* inputs to the wb_* and fwd_* outputs. All outputs decode combinationally from the register.
- Load alignment uses off = alu_result[1:0]:
  - funct3 000 (LB): byte at off, sign-extended.
  - 100 (LBU): byte at off, zero-extended.
  - 001 (LH): halfword selected by off[1], sign-extended. off[0] is ignored.
  - 101 (LHU): halfword selected by off[1], zero-extended.
  - 010 (LW) and all other codes: full word; off is ignored.
  - Byte at off n is read_data[8n+7:8n].
- wb_wd by result_src: 00 or 11 gives alu_result; 01 gives the aligned load; 10 gives pc_plus4.
- wb_we = valid & reg_write & (rd != 0). A write to x0 is never issued.
- wb_valid = valid.
- fwd_* mirror wb_* exactly, on the same cycle.
- instret:
  - Increments by 1 on a posedge where flush=0, stall=0 and mem_valid=1.
  - Wraps from 2^CNT_W-1 to 0.
  - Stalled cycles never count an instruction twice.
- While stall=1 the outputs stay constant. If wb_we=1, the register file rewrites the same value each cycle, which is harmless.
- Simultaneous flush and stall with mem_valid=1: a bubble is inserted and instret does not increment.

Test Plan:
- Reset: hold rst=1 with random inputs. All outputs stay 0. Release rst, drive one ALU op (rd=5, alu_result=32'h25) -> next cycle wb_we=1, wb_rd=5, wb_wd=32'h25, instret=1.
- Loads: read_data=32'h80FF7F01:
  - LB, off=2 -> 32'hFFFFFFFF.
  - LBU, off=3 -> 32'h00000080.
  - LH, off=2 -> 32'hFFFF80FF.
  - LHU, off=0 -> 32'h00007F01.
  - LW, off=1 -> 32'h80FF7F01.
- Sources: result_src=10, pc_plus4=32'h40 -> wb_wd=32'h40. rd=0 with reg_write=1 -> wb_we=0, wb_valid=1.
- Stall and flush:
  - Load A, then stall 3 cycles while inputs change -> outputs hold A and instret rises by only 1.
  - Then flush together with stall -> wb_valid=0, wb_we=0, instret unchanged.
- Counter: force instret to 2^CNT_W-1 (or use CNT_W=4 with 15 instructions) and issue one valid op -> instret=0.
- Async reset mid-stream: assert rst between clock edges while wb_we=1 -> wb_we, wb_wd and instret drop to 0 before the next edge.
